apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge_if.sv | 23 ++
 rtl/apb_master_bridge.sv | 104 ++++++++++
 tb/tb_apb_master_bridge.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// APB bus bundle between the bridge (master) and a peripheral (slave).
// Master drives the request phase; slave answers with data/ready/error.
interface apb_if;
  logic [31:0] addr;
  logic        sel;
  logic        enable;
  logic        write;
  logic [31:0] wdata;
  logic [3:0]  strb;
  logic [31:0] rdata;
  logic        ready;
  logic        slverr;

  modport master (
    output addr, sel, enable, write, wdata, strb,
    input  rdata, ready, slverr
  );

  modport slave (
    input  addr, sel, enable, write, wdata, strb,
    output rdata, ready, slverr
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding request/response to APB master bridge.
// Aborts an ACCESS phase after TIMEOUT wait cycles (0 disables it).
module apb_master_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  apb_if.master       apb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      req_ready   <= 1'b1;
      apb.addr    <= '0;
      apb.sel     <= 1'b0;
      apb.enable  <= 1'b0;
      apb.write   <= 1'b0;
      apb.wdata   <= '0;
      apb.strb    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state      <= SETUP;
            req_ready  <= 1'b0;
            wait_cnt   <= '0;
            apb.addr   <= req_addr;
            apb.write  <= req_write;
            apb.wdata  <= req_wdata;
            apb.strb   <= req_write ? req_strb : 4'b0000;
            apb.sel    <= 1'b1;
            apb.enable <= 1'b0;
          end
        end
        SETUP: begin
          state      <= ACCESS;
          apb.enable <= 1'b1;
        end
        ACCESS: begin
          if (apb.ready) begin
            state       <= RESP;
            apb.sel     <= 1'b0;
            apb.enable  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= apb.write ? 32'h0 : apb.rdata;
            rsp_err     <= apb.slverr;
            rsp_timeout <= 1'b0;
          end else if (TIMEOUT > 0 && wait_cnt == LAST) begin
            state       <= RESP;
            apb.sel     <= 1'b0;
            apb.enable  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else if (wait_cnt != '1) begin
            // saturates when timeout is disabled
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench: vector table of APB transfers against a byte-memory
// slave model, plus reset and handshake sequences.
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  apb_if apb ();

  apb_master_bridge #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .apb        (apb),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .req_strb   (req_strb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  // slave model
  logic [7:0] mem [0:255];
  int         s_wait;
  logic       s_never;
  logic       s_serr;
  int         acc_cnt;
  logic [7:0] ba;

  assign ba = apb.addr[7:0];
  assign apb.ready = apb.sel && apb.enable && !s_never
                     && (acc_cnt == s_wait);
  assign apb.slverr = apb.ready ? s_serr : 1'b0;
  assign apb.rdata = (apb.ready && !apb.write)
    ? {mem[ba + 8'd3], mem[ba + 8'd2], mem[ba + 8'd1], mem[ba]}
    : 32'hxxxx_xxxx;

  always @(posedge clk) begin
    if (apb.sel && apb.enable) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (apb.ready && apb.write) begin
      for (int i = 0; i < 4; i++)
        if (apb.strb[i]) mem[ba + 8'(i)] <= apb.wdata[8*i +: 8];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          wait_n;
    logic        never;
    logic        serr;
    int          hold;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_to;
    int          e_nacc;
  } vec_t;

  vec_t vecs [10];

  task automatic xfer(input vec_t v);
    int   cyc;
    int   nacc;
    logic stable_ok;
    logic strb_ok;
    logic setup_ok;
    logic hold_ok;
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    logic        w0;
    logic [31:0] h_rd;
    logic        h_er, h_to;

    s_wait  = v.wait_n;
    s_never = v.never;
    s_serr  = v.serr;
    @(negedge clk);
    rsp_ready = (v.hold == 0);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_write = v.wr;
    req_wdata = v.wdata;
    req_strb  = v.strb;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    setup_ok  = apb.sel && !apb.enable;
    a0 = apb.addr; d0 = apb.wdata; s0 = apb.strb; w0 = apb.write;
    stable_ok = (a0 == v.addr) && (w0 == v.wr);
    strb_ok   = 1'b1;
    nacc = 0;
    cyc  = 0;
    while (!rsp_valid && cyc < 40) begin
      if (apb.sel) begin
        if (apb.addr != a0 || apb.wdata != d0 || apb.strb != s0
            || apb.write != w0) stable_ok = 1'b0;
        if (!v.wr && apb.strb != 4'b0000) strb_ok = 1'b0;
        if (apb.enable) nacc++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", cyc, v.e_nacc + 1);
    chk("setup_phase", setup_ok, 1'b1);
    chk("addr_stable", stable_ok, 1'b1);
    chk("read_strb_zero", strb_ok, 1'b1);
    chk("access_cycles", nacc, v.e_nacc);
    chk("resp_bus_idle", {apb.sel, apb.enable}, 2'b00);
    chk("rsp_rdata", rsp_rdata, v.e_rdata);
    chk("rsp_err", rsp_err, v.e_err);
    chk("rsp_timeout", rsp_timeout, v.e_to);
    if (v.hold > 0) begin
      h_rd = rsp_rdata; h_er = rsp_err; h_to = rsp_timeout;
      hold_ok = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h99;
      for (int i = 0; i < v.hold; i++) begin
        @(posedge clk);
        #1;
        if (!rsp_valid || rsp_rdata != h_rd || rsp_err != h_er
            || rsp_timeout != h_to || req_ready) hold_ok = 1'b0;
      end
      req_valid = 1'b0;
      chk("rsp_hold", hold_ok, 1'b1);
      chk("req_ignored", apb.addr, v.addr);
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("consumed", {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    acc_cnt = 0;
    s_wait = 0; s_never = 1'b0; s_serr = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    req_wdata = '0; req_strb = '0; rsp_ready = 1'b0;

    vecs[0] = '{1'b1, 32'h10, 32'hA1B2C3D4, 4'hF, 0, 1'b0, 1'b0, 0,
                32'h0, 1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h10, 32'h0, 4'hF, 3, 1'b0, 1'b0, 0,
                32'hA1B2C3D4, 1'b0, 1'b0, 4};
    vecs[2] = '{1'b1, 32'h20, 32'h0, 4'hF, 0, 1'b0, 1'b0, 0,
                32'h0, 1'b0, 1'b0, 1};
    vecs[3] = '{1'b1, 32'h20, 32'h11223344, 4'h5, 1, 1'b0, 1'b0, 0,
                32'h0, 1'b0, 1'b0, 2};
    vecs[4] = '{1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 1'b0, 0,
                32'h00220044, 1'b0, 1'b0, 1};
    vecs[5] = '{1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, 1'b1, 5,
                32'hA1B2C3D4, 1'b1, 1'b0, 1};
    vecs[6] = '{1'b1, 32'h30, 32'hDEADBEEF, 4'hF, 0, 1'b1, 1'b0, 0,
                32'h0, 1'b1, 1'b1, 4};
    vecs[7] = '{1'b0, 32'h30, 32'h0, 4'h0, 2, 1'b0, 1'b0, 0,
                32'h0, 1'b0, 1'b0, 3};
    vecs[8] = '{1'b1, 32'h40, 32'hCAFEF00D, 4'hA, 0, 1'b0, 1'b1, 2,
                32'h0, 1'b1, 1'b0, 1};
    vecs[9] = '{1'b0, 32'h40, 32'h0, 4'h0, 1, 1'b0, 1'b0, 0,
                32'hCA00F000, 1'b0, 1'b0, 2};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel_en", {apb.sel, apb.enable}, 2'b00);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_addr", apb.addr, 32'h0);
    chk("rst_wdata", apb.wdata, 32'h0);
    chk("rst_wr_strb", {apb.write, apb.strb}, 5'h0);
    rst = 1'b0;
    chk("rst_req_ready", req_ready, 1'b1);

    for (int i = 0; i < 10; i++) xfer(vecs[i]);

    chk("mem_10", mem[8'h10], 8'hD4);
    chk("mem_11", mem[8'h11], 8'hC3);
    chk("mem_12", mem[8'h12], 8'hB2);
    chk("mem_13", mem[8'h13], 8'hA1);

    // reset landing in the second ACCESS cycle
    s_wait = 3; s_never = 1'b0; s_serr = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h10; req_write = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_access1", {apb.sel, apb.enable}, 2'b11);
    @(posedge clk);
    #1;
    chk("mid_access2", {apb.sel, apb.enable}, 2'b11);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_bus", {apb.sel, apb.enable}, 2'b00);
    chk("abort_rsp", rsp_valid, 1'b0);
    chk("abort_req_ready", req_ready, 1'b1);
    chk("abort_addr", apb.addr, 32'h0);
    begin
      logic seen = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk);
        #1;
        if (rsp_valid || apb.sel) seen = 1'b1;
      end
      rsp_ready = 1'b0;
      chk("no_abort_rsp", seen, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
